// File: rtl/regfile_hilo_if.sv
// Register-file side bus: WB-stage write payload in, ID-stage read ports and debug counters out.
interface regfile_hilo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned BUS_W = 3 * DATA_W + AW + 3;

  logic [BUS_W-1:0]  wb_to_rf_bus;
  logic [AW-1:0]     raddr1;
  logic [AW-1:0]     raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_rdata;
  logic [DATA_W-1:0] lo_rdata;
  logic [CNT_W-1:0]  wr_count;
  logic [CNT_W-1:0]  hilo_count;

  modport master (
    output wb_to_rf_bus, raddr1, raddr2,
    input  rdata1, rdata2, hi_rdata, lo_rdata, wr_count, hilo_count
  );

  modport slave (
    input  wb_to_rf_bus, raddr1, raddr2,
    output rdata1, rdata2, hi_rdata, lo_rdata, wr_count, hilo_count
  );
endinterface

// File: rtl/regfile_hilo.sv
// Architectural GPR file plus HI/LO pair with same-cycle write-through bypass on every read port,
// and retired-write counters for debug.
module regfile_hilo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  regfile_hilo_if.slave  rf
);
  localparam int unsigned AW = $clog2(NREG);

  typedef struct packed {
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi_wdata;
    logic [DATA_W-1:0] lo_wdata;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
  } wb_bus_t;

  wb_bus_t           wb;
  logic              gpr_commit;
  logic              hilo_commit;
  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  hilo_cnt_q, hilo_cnt_d;

  assign wb          = rf.wb_to_rf_bus;
  assign gpr_commit  = wb.rf_we && (wb.rf_waddr != '0);
  assign hilo_commit = wb.hi_we || wb.lo_we;

  // Entry 0 is reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) gpr_q[i] <= '0;
    end else if (gpr_commit) begin
      gpr_q[wb.rf_waddr] <= wb.rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      wr_cnt_q   <= '0;
      hilo_cnt_q <= '0;
    end else begin
      if (wb.hi_we) hi_q <= wb.hi_wdata;
      if (wb.lo_we) lo_q <= wb.lo_wdata;
      wr_cnt_q   <= wr_cnt_d;
      hilo_cnt_q <= hilo_cnt_d;
    end
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    hilo_cnt_d = hilo_cnt_q;
    if (gpr_commit)  wr_cnt_d   = wr_cnt_q + CNT_W'(1);
    if (hilo_commit) hilo_cnt_d = hilo_cnt_q + CNT_W'(1);
  end

  // Reads are forced to zero during reset so the bypass cannot leak an ignored write.
  always_comb begin
    rf.rdata1 = '0;
    if (rst && rf.raddr1 != '0) begin
      if (wb.rf_we && wb.rf_waddr == rf.raddr1) rf.rdata1 = wb.rf_wdata;
      else                                      rf.rdata1 = gpr_q[rf.raddr1];
    end
  end

  always_comb begin
    rf.rdata2 = '0;
    if (rst && rf.raddr2 != '0) begin
      if (wb.rf_we && wb.rf_waddr == rf.raddr2) rf.rdata2 = wb.rf_wdata;
      else                                      rf.rdata2 = gpr_q[rf.raddr2];
    end
  end

  always_comb begin
    rf.hi_rdata = '0;
    rf.lo_rdata = '0;
    if (rst) begin
      rf.hi_rdata = wb.hi_we ? wb.hi_wdata : hi_q;
      rf.lo_rdata = wb.lo_we ? wb.lo_wdata : lo_q;
    end
  end

  assign rf.wr_count   = wr_cnt_q;
  assign rf.hilo_count = hilo_cnt_q;
endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: vector table for steady-state behaviour plus reset sequences.
module tb_regfile_hilo;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  regfile_hilo_if #(.DATA_W(32), .AW(5), .CNT_W(32)) rf_bus ();

  regfile_hilo #(.DATA_W(32), .NREG(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [31:0] e_wr;
    logic [31:0] e_hl;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rf_we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic hi_we, input logic lo_we, input logic [31:0] hi_wd,
                       input logic [31:0] lo_wd, input logic [4:0] ra1, input logic [4:0] ra2);
    rf_bus.wb_to_rf_bus = {hi_we, lo_we, hi_wd, lo_wd, rf_we, waddr, wdata};
    rf_bus.raddr1       = ra1;
    rf_bus.raddr2       = ra2;
  endtask

  task automatic drive_idle(input logic [4:0] ra1, input logic [4:0] ra2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ra1, ra2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //             we waddr wdata          hw lw hi_wd          lo_wd          ra1 ra2 rd1            rd2            hi             lo             wr  hl
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd0, 32'd0};
    vecs[1]  = '{1'b1, 5'd1,  32'h11111111, 1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 5'd0,  32'h11111111, 32'h0,        32'h0,        32'h0,        32'd1, 32'd0};
    vecs[2]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 5'd31, 32'h11111111, 32'hFFFFFFFF, 32'h0,        32'h0,        32'd2, 32'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd1, 5'd31, 32'h11111111, 32'hFFFFFFFF, 32'h0,        32'h0,        32'd2, 32'd0};
    vecs[4]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd2, 32'd0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd1,  32'h0,        32'h11111111, 32'h0,        32'h0,        32'd2, 32'd0};
    vecs[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        32'h0,        5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'd3, 32'd0};
    vecs[7]  = '{1'b0, 5'd7,  32'h5A5A5A5A, 1'b0, 1'b0, 32'h0,        32'h0,        5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'd3, 32'd0};
    vecs[8]  = '{1'b1, 5'd7,  32'h5A5A5A5A, 1'b0, 1'b0, 32'h0,        32'h0,        5'd7, 5'd7,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0,        32'h0,        32'd4, 32'd0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd7, 5'd1,  32'h5A5A5A5A, 32'h11111111, 32'h0,        32'h0,        32'd4, 32'd0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 32'h1,        32'h2,        5'd0, 5'd0,  32'h0,        32'h0,        32'h1,        32'h0,        32'd4, 32'd1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'h1,        32'h0,        32'd4, 32'd1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 5'd0, 5'd0,  32'h0,        32'h0,        32'hAAAA0000, 32'h0000BBBB, 32'd4, 32'd2};
    vecs[13] = '{1'b1, 5'd3,  32'hCAFEF00D, 1'b0, 1'b1, 32'h0,        32'h00000077, 5'd3, 5'd31, 32'hCAFEF00D, 32'hFFFFFFFF, 32'hAAAA0000, 32'h00000077, 32'd5, 32'd3};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd3, 5'd3,  32'hCAFEF00D, 32'hCAFEF00D, 32'hAAAA0000, 32'h00000077, 32'd5, 32'd3};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        5'd31, 5'd7, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hAAAA0000, 32'h00000077, 32'd5, 32'd3};

    // Writes held during reset must be ignored, including on the bypass path.
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 5'd5, 5'd5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_rdata1", rf_bus.rdata1, 32'h0);
    chk("rst_hold_hi", rf_bus.hi_rdata, 32'h0);
    chk("rst_hold_wr_count", rf_bus.wr_count, 32'h0);
    chk("rst_hold_hilo_count", rf_bus.hilo_count, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive_idle(5'd5, 5'd0);
    @(posedge clk);
    #1;
    chk("rst_release_rdata1", rf_bus.rdata1, 32'h0);
    chk("rst_release_lo", rf_bus.lo_rdata, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rf_we, vecs[i].waddr, vecs[i].wdata, vecs[i].hi_we, vecs[i].lo_we,
            vecs[i].hi_wd, vecs[i].lo_wd, vecs[i].ra1, vecs[i].ra2);
      #1;
      chk($sformatf("v%0d_rdata1", i), rf_bus.rdata1, vecs[i].e_rd1);
      chk($sformatf("v%0d_rdata2", i), rf_bus.rdata2, vecs[i].e_rd2);
      chk($sformatf("v%0d_hi", i), rf_bus.hi_rdata, vecs[i].e_hi);
      chk($sformatf("v%0d_lo", i), rf_bus.lo_rdata, vecs[i].e_lo);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_count", i), rf_bus.wr_count, vecs[i].e_wr);
      chk($sformatf("v%0d_hilo_count", i), rf_bus.hilo_count, vecs[i].e_hl);
    end

    // Async reset between edges with a write pending on the bus.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h00001234, 1'b1, 1'b0, 32'h99990000, 32'h0, 5'd9, 5'd31);
    #1;
    chk("pre_rst_bypass", rf_bus.rdata1, 32'h00001234);
    chk("pre_rst_r31", rf_bus.rdata2, 32'hFFFFFFFF);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rdata1", rf_bus.rdata1, 32'h0);
    chk("async_rdata2", rf_bus.rdata2, 32'h0);
    chk("async_hi", rf_bus.hi_rdata, 32'h0);
    chk("async_lo", rf_bus.lo_rdata, 32'h0);
    chk("async_wr_count", rf_bus.wr_count, 32'h0);
    chk("async_hilo_count", rf_bus.hilo_count, 32'h0);
    @(posedge clk);
    #1;
    chk("in_rst_wr_count", rf_bus.wr_count, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive_idle(5'd9, 5'd31);
    #1;
    chk("post_rst_r9", rf_bus.rdata1, 32'h0);
    chk("post_rst_r31", rf_bus.rdata2, 32'h0);
    chk("post_rst_hi", rf_bus.hi_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_wr_count", rf_bus.wr_count, 32'h0);
    chk("post_rst_hilo_count", rf_bus.hilo_count, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
